serial_wb_capture_slave: RTL and testbench

Wishbone slave that acts as the responder for the serial bridge's Wishbone master, giving the host a logic-analyzer capture engine. It samples a 32-bit probe bus into a circular on-chip buffer. It triggers on a masked pattern match, records a programmed number of post-trigger samples, then stops. The host arms the engine and reads status and the captured buffer through 32-bit Wishbone register and memory windows.

---
 rtl/serial_wb_capture_slave.sv | 171 +++++++++++++++++
 tb/tb_serial_wb_capture_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_wb_capture_slave.sv
// Wishbone-attached logic-analyzer capture engine: masked-pattern trigger,
// circular sample buffer with post-trigger count, register and buffer windows.
module serial_wb_capture_slave #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] sample_i,
  input  logic        sample_en_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        busy_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED, DONE} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] trig_ptr_q, trig_ptr_d;
  logic [DEPTH_LOG2-1:0] postcount_q;
  logic [31:0]           trig_mask_q, trig_value_q;
  logic [31:0]           mem [DEPTH];
  logic                  mem_we, match;

  logic                  ack_p1, err_p1, rty_p1, buf_rd_p1;
  logic [31:0]           dat_p1, buf_dat_p1;

  logic                  pending, accept, reg_sel, adr_hi_bad, reg_bad, buf_bad, wr_bad;
  logic                  acc_err, acc_rty, buf_rd_acc, reg_wr, ctrl_wr;
  logic [2:0]            reg_idx;
  logic [DEPTH_LOG2-1:0] buf_idx;
  logic [31:0]           reg_rdata;
  logic                  unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign busy_o  = (state_q == ARMED) || (state_q == TRIGGERED);
  assign pending = ack_p1 || err_p1 || rty_p1 || buf_rd_p1;
  assign accept  = wbs_cyc_i && wbs_stb_i && !pending;

  // Address decode and termination classification for the request in cycle N
  assign reg_sel    = !wbs_adr_i[15];
  assign reg_idx    = wbs_adr_i[4:2];
  assign buf_idx    = wbs_adr_i[DEPTH_LOG2+1:2];
  assign adr_hi_bad = |wbs_adr_i[31:16];
  assign reg_bad    = reg_sel && ((reg_idx > 3'd4) || (|wbs_adr_i[14:5]));
  assign buf_bad    = !reg_sel && ((wbs_adr_i[14:2] >> DEPTH_LOG2) != '0);
  assign wr_bad     = wbs_we_i && ((wbs_sel_i != 4'hf) || !reg_sel || (reg_idx == 3'd4));
  assign acc_err    = adr_hi_bad || reg_bad || buf_bad || wr_bad;
  assign acc_rty    = !acc_err && !reg_sel && busy_o;
  assign buf_rd_acc = accept && !acc_err && !reg_sel && !busy_o;
  assign reg_wr     = accept && wbs_we_i && !acc_err;
  assign ctrl_wr    = reg_wr && (reg_idx == 3'd0);

  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      3'd0: reg_rdata = {29'b0, state_q == DONE,
                         (state_q == TRIGGERED) || (state_q == DONE), busy_o};
      3'd1: reg_rdata = trig_mask_q;
      3'd2: reg_rdata = trig_value_q;
      3'd3: reg_rdata = 32'(postcount_q);
      3'd4: reg_rdata = 32'(trig_ptr_q);
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      postcount_q  <= '0;
    end else if (reg_wr) begin
      case (reg_idx)
        3'd1: trig_mask_q  <= wbs_dat_i;
        3'd2: trig_value_q <= wbs_dat_i;
        3'd3: postcount_q  <= wbs_dat_i[DEPTH_LOG2-1:0];
        default: ;
      endcase
    end
  end

  // Capture FSM: control writes take priority over the sample in the same cycle
  assign match = ((sample_i ^ trig_value_q) & trig_mask_q) == '0;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    trig_ptr_d = trig_ptr_q;
    mem_we     = 1'b0;
    if (ctrl_wr && wbs_dat_i[1]) begin
      state_d = IDLE;
    end else if (ctrl_wr && wbs_dat_i[0]) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
    end else begin
      case (state_q)
        ARMED: if (sample_en_i) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (match) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d      = postcount_q;
            state_d    = (postcount_q == '0) ? DONE : TRIGGERED;
          end
        end
        TRIGGERED: if (sample_en_i) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == DEPTH_LOG2'(1)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      trig_ptr_q <= trig_ptr_d;
    end
  end

  // Response stage p1: register/err/rty terminate here; buffer reads add one RAM cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_p1    <= 1'b0;
      err_p1    <= 1'b0;
      rty_p1    <= 1'b0;
      buf_rd_p1 <= 1'b0;
    end else begin
      ack_p1    <= (accept && !acc_err && reg_sel) || (buf_rd_p1 && wbs_cyc_i);
      err_p1    <= accept && acc_err;
      rty_p1    <= accept && acc_rty;
      buf_rd_p1 <= buf_rd_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= sample_i;
    if (buf_rd_acc) buf_dat_p1 <= mem[buf_idx];
    if (buf_rd_p1) dat_p1 <= buf_dat_p1;
    else if (accept) dat_p1 <= wbs_we_i ? '0 : reg_rdata;
  end

  // Terminations are suppressed when the master has dropped the cycle
  assign wbs_ack_o = ack_p1 && wbs_cyc_i;
  assign wbs_err_o = err_p1 && wbs_cyc_i;
  assign wbs_rty_o = rty_p1 && wbs_cyc_i;
  assign wbs_dat_o = wbs_ack_o ? dat_p1 : '0;

endmodule

// File: tb/tb_serial_wb_capture_slave.sv
// Scoreboard bench for serial_wb_capture_slave with DEPTH_LOG2=4: directed
// bus/sample sequences push expected terminations; a negedge monitor checks them.
module tb_serial_wb_capture_slave;
  localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_RTY = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] sample_i;
  logic        sample_en_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o, busy_o;

  serial_wb_capture_slave #(.DEPTH_LOG2(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .sample_en_i(sample_en_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_i(wbs_sel_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  typedef struct packed {
    logic [31:0] act;
    logic [31:0] want;
  } dchk_t;

  exp_t        exp_q[$];
  dchk_t       dchk_q[$];
  string       dname_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  logic        mon_en = 1'b0;
  logic [31:0] cycle = '0;

  always @(posedge clk_i) cycle <= cycle + 1;

  exp_t       m_e;
  dchk_t      m_d;
  string      m_nm;
  logic [1:0] m_kind;

  // Monitor: sole owner of the check/error counters
  always @(negedge clk_i) begin
    while (dchk_q.size() > 0) begin
      m_d  = dchk_q.pop_front();
      m_nm = dname_q.pop_front();
      checks++;
      if (m_d.act !== m_d.want) begin
        errors++;
        $display("FAIL %s: got %h, want %h", m_nm, m_d.act, m_d.want);
      end
    end
    if (mon_en && (wbs_ack_o || wbs_err_o || wbs_rty_o)) begin
      m_kind = wbs_ack_o ? K_ACK : (wbs_err_o ? K_ERR : K_RTY);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got kind %0d data %h at cycle %0d, want none",
                 m_kind, wbs_dat_o, cycle);
      end else begin
        m_e = exp_q.pop_front();
        if ($countones({wbs_ack_o, wbs_err_o, wbs_rty_o}) != 1 || m_kind != m_e.kind ||
            wbs_dat_o !== m_e.data || cycle != m_e.due) begin
          errors++;
          $display("FAIL rsp: got kind %0d data %h cycle %0d, want kind %0d data %h cycle %0d",
                   m_kind, wbs_dat_o, cycle, m_e.kind, m_e.data, m_e.due);
        end
      end
      rsp_seen++;
    end
  end

  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] want);
    dchk_t d;
    d.act  = act;
    d.want = want;
    dchk_q.push_back(d);
    dname_q.push_back(nm);
  endtask

  // Called just after a rising edge; holds the request until a termination is seen
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [1:0] kind,
                     input logic [31:0] want, input int lat);
    exp_t e;
    int   seen0;
    int   waited;
    seen0     = rsp_seen;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    e.kind = kind;
    e.data = want;
    e.due  = cycle + 32'(lat);
    exp_q.push_back(e);
    waited = 0;
    while (rsp_seen == seen0 && waited < 8) begin
      @(posedge clk_i); #1;
      waited++;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (rsp_seen == seen0) begin
      dchk("rsp_timeout", 32'(rsp_seen - seen0), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic rd_reg(input logic [31:0] adr, input logic [31:0] want);
    bus(1'b0, adr, '0, 4'hf, K_ACK, want, 1);
  endtask

  task automatic wr_reg(input logic [31:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, 4'hf, K_ACK, '0, 1);
  endtask

  task automatic rd_buf(input int idx, input logic [31:0] want);
    bus(1'b0, 32'h8000 | 32'(idx << 2), '0, 4'hf, K_ACK, want, 2);
  endtask

  task automatic run_samples(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      sample_i    = base + 32'(i);
      sample_en_i = 1'b1;
      @(posedge clk_i); #1;
    end
    sample_en_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; sample_i = '0; sample_en_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hf;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;

    // Reset asserted while bus traffic is active
    repeat (2) @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h4;
    @(posedge clk_i); #3;
    rst_i = 1'b0; #1;
    dchk("rst_ack", 32'(wbs_ack_o), 32'd0);
    dchk("rst_err", 32'(wbs_err_o), 32'd0);
    dchk("rst_rty", 32'(wbs_rty_o), 32'd0);
    dchk("rst_dat", wbs_dat_o, 32'd0);
    dchk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    dchk("rst_ack_held", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    mon_en = 1'b1;
    rd_reg(32'h0, 32'h0);
    rd_reg(32'h4, 32'h0);
    rd_reg(32'h8, 32'h0);
    rd_reg(32'hC, 32'h0);
    rd_reg(32'h10, 32'h0);

    // Exact-match trigger on 0x10 with three post-trigger samples
    wr_reg(32'h4, 32'hFFFF_FFFF);
    wr_reg(32'h8, 32'h0000_0010);
    wr_reg(32'hC, 32'd3);
    wr_reg(32'h0, 32'h1);
    dchk("busy_armed", 32'(busy_o), 32'd1);
    run_samples(32'h0, 20);
    rd_reg(32'h0, 32'h6);
    rd_reg(32'h10, 32'h0);
    rd_buf(0, 32'h10);
    rd_buf(1, 32'h11);
    rd_buf(2, 32'h12);
    rd_buf(3, 32'h13);
    rd_buf(4, 32'h04);
    rd_buf(15, 32'h0F);
    dchk("busy_done", 32'(busy_o), 32'd0);

    // Error terminations leave all state untouched
    bus(1'b1, 32'h4, 32'h1234, 4'h3, K_ERR, '0, 1);
    bus(1'b1, 32'h14, 32'h1, 4'hf, K_ERR, '0, 1);
    bus(1'b1, 32'h0001_0000, 32'h1, 4'hf, K_ERR, '0, 1);
    bus(1'b1, 32'h8000, 32'hDEAD, 4'hf, K_ERR, '0, 1);
    bus(1'b1, 32'h10, 32'h7, 4'hf, K_ERR, '0, 1);
    bus(1'b0, 32'h8040, '0, 4'hf, K_ERR, '0, 1);
    bus(1'b0, 32'h18, '0, 4'hf, K_ERR, '0, 1);
    bus(1'b0, 32'h20, '0, 4'hf, K_ERR, '0, 1);
    rd_reg(32'h4, 32'hFFFF_FFFF);
    rd_reg(32'h0, 32'h6);
    rd_buf(0, 32'h10);

    // Zero mask and zero post-count: first enabled sample completes the capture
    wr_reg(32'h4, 32'h0);
    wr_reg(32'hC, 32'h0);
    wr_reg(32'h0, 32'h1);
    bus(1'b0, 32'h8000, '0, 4'hf, K_RTY, '0, 1);
    rd_reg(32'h0, 32'h1);
    run_samples(32'hA5A5_0001, 1);
    rd_reg(32'h0, 32'h6);
    rd_reg(32'h10, 32'h0);
    rd_buf(0, 32'hA5A5_0001);

    // Abort wins over arm while TRIGGERED
    wr_reg(32'h4, 32'hFFFF_FFFF);
    wr_reg(32'h8, 32'h5);
    wr_reg(32'hC, 32'h2);
    wr_reg(32'h0, 32'h1);
    run_samples(32'h0, 6);
    rd_reg(32'h0, 32'h3);
    rd_reg(32'h10, 32'h5);
    wr_reg(32'h0, 32'h3);
    rd_reg(32'h0, 32'h0);
    dchk("busy_abort", 32'(busy_o), 32'd0);

    // Master drops cyc in the response cycle: no termination reaches the bus
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h8;
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk_i);
    dchk("cyc_drop_ack", 32'(wbs_ack_o), 32'd0);
    @(posedge clk_i); #1;
    rd_reg(32'h8, 32'h5);

    // Post-count truncation and full wrap; re-arm keeps the old trigger pointer
    wr_reg(32'h8, 32'h103);
    wr_reg(32'hC, 32'hFFFF_FFFF);
    rd_reg(32'hC, 32'hF);
    wr_reg(32'h0, 32'h1);
    rd_reg(32'h10, 32'h5);
    run_samples(32'h100, 19);
    rd_reg(32'h0, 32'h6);
    rd_reg(32'h10, 32'h3);
    rd_buf(3, 32'h103);
    rd_buf(2, 32'h112);
    rd_buf(0, 32'h110);
    rd_buf(4, 32'h104);
    rd_buf(15, 32'h10F);

    repeat (3) @(posedge clk_i); #1;
    dchk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
